// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: decode control codes and
// 2-bit BHT counter states, plus the saturating counter step.
package bp_pkg;

  typedef enum logic [1:0] {
    JC_NONE   = 2'b00,
    JC_BRANCH = 2'b01,
    JC_JAL    = 2'b10,
    JC_JALR   = 2'b11
  } jump_code_e;

  typedef enum logic [2:0] {
    BC_EQ  = 3'b000,
    BC_NE  = 3'b001,
    BC_LT  = 3'b100,
    BC_GE  = 3'b101,
    BC_LTU = 3'b110,
    BC_GEU = 3'b111
  } branch_code_e;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_cnt_e;

  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST)  ? cnt : cnt + 2'd1;
    else       return (cnt == SNT) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_bht_btb_if.sv
// Fetch-side prediction and decode-side resolve signals of the predictor.
interface bp_bht_btb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_pred_pc;
  logic            f_pred_taken;
  logic            d_valid;
  logic            d_stall;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_pc_predicted;
  logic [XLEN-1:0] d_imm;
  logic [XLEN-1:0] d_reg_data1;
  logic [XLEN-1:0] d_reg_data2;
  logic [1:0]      d_jump_code;
  logic [2:0]      d_branch_code;
  logic            d_cannot_predict;
  logic [XLEN-1:0] d_nextpc;
  logic            d_fail_predict;

  modport master (
    output f_pc, d_valid, d_stall, d_pc, d_pc_predicted, d_imm, d_reg_data1,
           d_reg_data2, d_jump_code, d_branch_code, d_cannot_predict,
    input  f_pred_pc, f_pred_taken, d_nextpc, d_fail_predict
  );

  modport slave (
    input  f_pc, d_valid, d_stall, d_pc, d_pc_predicted, d_imm, d_reg_data1,
           d_reg_data2, d_jump_code, d_branch_code, d_cannot_predict,
    output f_pred_pc, f_pred_taken, d_nextpc, d_fail_predict
  );
endinterface

// File: rtl/bp_branch_cond.sv
// Conditional branch comparator; reserved funct3 codes resolve not-taken.
module bp_branch_cond
  import bp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      branch_code,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);
  always_comb begin
    taken = 1'b0;
    case (branch_code)
      BC_EQ:   taken = (rs1 == rs2);
      BC_NE:   taken = (rs1 != rs2);
      BC_LT:   taken = ($signed(rs1) <  $signed(rs2));
      BC_GE:   taken = ($signed(rs1) >= $signed(rs2));
      BC_LTU:  taken = (rs1 <  rs2);
      BC_GEU:  taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/bp_bht_btb.sv
// Direct-mapped BTB plus 2-bit BHT: combinational fetch prediction from
// registered tables, decode-stage resolve, table training and perf counters.
module bp_bht_btb
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  bp_bht_btb_if.slave      bus,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);
  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = XLEN - BTB_IDX_W - 2;

  logic [1:0]      bht     [BHT_N];
  logic            btb_vld [BTB_N];
  logic            btb_unc [BTB_N];
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [XLEN-1:0] btb_tgt [BTB_N];

  // Fetch lookup reads only registered state, so a same-cycle update is
  // seen by fetch one cycle later.
  logic [BHT_IDX_W-1:0] f_bidx;
  logic [BTB_IDX_W-1:0] f_tidx;
  logic                 f_hit, f_taken;

  assign f_bidx  = bus.f_pc[BHT_IDX_W+1:2];
  assign f_tidx  = bus.f_pc[BTB_IDX_W+1:2];
  assign f_hit   = btb_vld[f_tidx] && (btb_tag[f_tidx] == bus.f_pc[XLEN-1:BTB_IDX_W+2]);
  assign f_taken = f_hit && (btb_unc[f_tidx] || bht[f_bidx][1]);

  assign bus.f_pred_taken = f_taken;
  assign bus.f_pred_pc    = f_taken ? btb_tgt[f_tidx] : bus.f_pc + XLEN'(4);

  logic            br_taken, d_taken, upd;
  logic [XLEN-1:0] nextpc;
  logic [BHT_IDX_W-1:0] d_bidx;
  logic [BTB_IDX_W-1:0] d_tidx;

  bp_branch_cond #(.XLEN(XLEN)) u_cond (
    .branch_code (bus.d_branch_code),
    .rs1         (bus.d_reg_data1),
    .rs2         (bus.d_reg_data2),
    .taken       (br_taken)
  );

  always_comb begin
    d_taken = 1'b0;
    nextpc  = bus.d_pc + XLEN'(4);
    case (bus.d_jump_code)
      JC_JALR: begin
        d_taken = 1'b1;
        nextpc  = (bus.d_reg_data1 + bus.d_imm) & ~XLEN'(1);
      end
      JC_JAL: begin
        d_taken = 1'b1;
        nextpc  = bus.d_pc + bus.d_imm;
      end
      JC_BRANCH: begin
        d_taken = br_taken;
        if (br_taken) nextpc = bus.d_pc + bus.d_imm;
      end
      default: ;
    endcase
  end

  assign bus.d_nextpc       = nextpc;
  assign bus.d_fail_predict = bus.d_valid && !bus.d_cannot_predict &&
                              (nextpc != bus.d_pc_predicted);

  assign upd    = bus.d_valid && !bus.d_stall && (bus.d_jump_code != JC_NONE);
  assign d_bidx = bus.d_pc[BHT_IDX_W+1:2];
  assign d_tidx = bus.d_pc[BTB_IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= WNT;
      for (int i = 0; i < BTB_N; i++) btb_vld[i] <= 1'b0;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (upd) begin
      bht[d_bidx] <= (bus.d_jump_code == JC_BRANCH) ? bht_next(bht[d_bidx], d_taken) : ST;
      if (d_taken) btb_vld[d_tidx] <= 1'b1;
      perf_branches <= perf_branches + CNT_W'(1);
      if (bus.d_fail_predict) perf_mispredicts <= perf_mispredicts + CNT_W'(1);
    end
  end

  // Tag/target/uncond payload is only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (rst_n && upd && d_taken) begin
      btb_tag[d_tidx] <= bus.d_pc[XLEN-1:BTB_IDX_W+2];
      btb_tgt[d_tidx] <= nextpc;
      btb_unc[d_tidx] <= (bus.d_jump_code != JC_BRANCH);
    end
  end
endmodule

// File: tb/tb_bp_bht_btb.sv
// Directed bench for bp_bht_btb: one task per scenario, inline checks.
module tb_bp_bht_btb;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] perf_branches, perf_mispredicts;
  int          vec = 0;
  int          err = 0;

  bp_bht_btb_if #(.XLEN(32)) bus();

  bp_bht_btb #(.XLEN(32), .BHT_IDX_W(6), .BTB_IDX_W(4), .CNT_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.d_valid = 1'b0; bus.d_stall = 1'b0; bus.d_cannot_predict = 1'b0;
    bus.d_pc = '0; bus.d_pc_predicted = '0; bus.d_imm = '0;
    bus.d_reg_data1 = '0; bus.d_reg_data2 = '0;
    bus.d_jump_code = 2'b00; bus.d_branch_code = 3'b000;
  endtask

  task automatic drv(input logic [31:0] pc, pred, imm, r1, r2,
                     input logic [1:0] jc, input logic [2:0] bc);
    bus.d_valid = 1'b1; bus.d_stall = 1'b0; bus.d_cannot_predict = 1'b0;
    bus.d_pc = pc; bus.d_pc_predicted = pred; bus.d_imm = imm;
    bus.d_reg_data1 = r1; bus.d_reg_data2 = r2;
    bus.d_jump_code = jc; bus.d_branch_code = bc;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // update request held during reset must be dropped
    drv(32'h100, 32'h104, 32'h40, 32'd5, 32'd5, 2'b01, 3'b000);
    bus.f_pc = 32'h100;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    idle();
    #1;
    vec++; if (bus.f_pred_taken !== 1'b0) begin err++; $display("FAIL reset_taken: got %b want 0", bus.f_pred_taken); end
    vec++; if (bus.f_pred_pc !== 32'h104) begin err++; $display("FAIL reset_pred_pc: got %h want 00000104", bus.f_pred_pc); end
    vec++; if (perf_branches !== 32'd0) begin err++; $display("FAIL reset_perf_br: got %0d want 0", perf_branches); end
    vec++; if (perf_mispredicts !== 32'd0) begin err++; $display("FAIL reset_perf_mis: got %0d want 0", perf_mispredicts); end
  endtask

  task automatic test_training();
    do_reset();
    bus.f_pc = 32'h100;
    drv(32'h100, 32'h104, 32'h40, 32'd5, 32'd5, 2'b01, 3'b000);
    #1;
    vec++; if (bus.d_nextpc !== 32'h140) begin err++; $display("FAIL train_nextpc: got %h want 00000140", bus.d_nextpc); end
    vec++; if (bus.d_fail_predict !== 1'b1) begin err++; $display("FAIL train_fail1: got %b want 1", bus.d_fail_predict); end
    vec++; if (bus.f_pred_taken !== 1'b0) begin err++; $display("FAIL train_preupdate: got %b want 0", bus.f_pred_taken); end
    tick();
    bus.d_pc_predicted = 32'h140;
    #1;
    vec++; if (bus.d_fail_predict !== 1'b0) begin err++; $display("FAIL train_fail2: got %b want 0", bus.d_fail_predict); end
    vec++; if (bus.f_pred_taken !== 1'b1) begin err++; $display("FAIL train_taken: got %b want 1", bus.f_pred_taken); end
    vec++; if (bus.f_pred_pc !== 32'h140) begin err++; $display("FAIL train_pred_pc: got %h want 00000140", bus.f_pred_pc); end
    tick();
    idle();
    #1;
    vec++; if (perf_branches !== 32'd2) begin err++; $display("FAIL train_perf_br: got %0d want 2", perf_branches); end
    vec++; if (perf_mispredicts !== 32'd1) begin err++; $display("FAIL train_perf_mis: got %0d want 1", perf_mispredicts); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.f_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      drv(32'h200, 32'h220, 32'h20, 32'd7, 32'd7, 2'b01, 3'b000);
      tick();
    end
    idle();
    #1;
    vec++; if (bus.f_pred_taken !== 1'b1) begin err++; $display("FAIL sat_taken3: got %b want 1", bus.f_pred_taken); end
    vec++; if (bus.f_pred_pc !== 32'h220) begin err++; $display("FAIL sat_pc3: got %h want 00000220", bus.f_pred_pc); end
    drv(32'h200, 32'h220, 32'h20, 32'd1, 32'd2, 2'b01, 3'b000);
    #1;
    vec++; if (bus.d_nextpc !== 32'h204) begin err++; $display("FAIL sat_nt_nextpc: got %h want 00000204", bus.d_nextpc); end
    tick();
    idle();
    #1;
    vec++; if (bus.f_pred_taken !== 1'b1) begin err++; $display("FAIL sat_taken2: got %b want 1", bus.f_pred_taken); end
    vec++; if (bus.f_pred_pc !== 32'h220) begin err++; $display("FAIL sat_pc2: got %h want 00000220", bus.f_pred_pc); end
    drv(32'h200, 32'h220, 32'h20, 32'd1, 32'd2, 2'b01, 3'b000);
    tick();
    idle();
    #1;
    vec++; if (bus.f_pred_taken !== 1'b0) begin err++; $display("FAIL sat_taken1: got %b want 0", bus.f_pred_taken); end
    vec++; if (bus.f_pred_pc !== 32'h204) begin err++; $display("FAIL sat_pc1: got %h want 00000204", bus.f_pred_pc); end
    vec++; if (perf_branches !== 32'd6) begin err++; $display("FAIL sat_perf_br: got %0d want 6", perf_branches); end
    vec++; if (perf_mispredicts !== 32'd2) begin err++; $display("FAIL sat_perf_mis: got %0d want 2", perf_mispredicts); end
  endtask

  task automatic test_jumps();
    do_reset();
    drv(32'h300, 32'h304, 32'h10, 32'h1001, 32'h0, 2'b11, 3'b000);
    #1;
    vec++; if (bus.d_nextpc !== 32'h1010) begin err++; $display("FAIL jalr_nextpc: got %h want 00001010", bus.d_nextpc); end
    vec++; if (bus.d_fail_predict !== 1'b1) begin err++; $display("FAIL jalr_fail: got %b want 1", bus.d_fail_predict); end
    tick();
    idle();
    bus.f_pc = 32'h300;
    #1;
    vec++; if (bus.f_pred_taken !== 1'b1) begin err++; $display("FAIL jalr_taken: got %b want 1", bus.f_pred_taken); end
    vec++; if (bus.f_pred_pc !== 32'h1010) begin err++; $display("FAIL jalr_pred_pc: got %h want 00001010", bus.f_pred_pc); end
    drv(32'h400, 32'h3F8, 32'hFFFF_FFF8, 32'h0, 32'h0, 2'b10, 3'b000);
    #1;
    vec++; if (bus.d_nextpc !== 32'h3F8) begin err++; $display("FAIL jal_nextpc: got %h want 000003f8", bus.d_nextpc); end
    vec++; if (bus.d_fail_predict !== 1'b0) begin err++; $display("FAIL jal_fail: got %b want 0", bus.d_fail_predict); end
    tick();
    idle();
    bus.f_pc = 32'h400;
    #1;
    vec++; if (bus.f_pred_pc !== 32'h3F8) begin err++; $display("FAIL jal_pred_pc: got %h want 000003f8", bus.f_pred_pc); end
    // JALR target wraps past 2^32 and drops bit 0
    bus.d_jump_code = 2'b11; bus.d_reg_data1 = 32'hFFFF_FFF1; bus.d_imm = 32'h20;
    #1;
    vec++; if (bus.d_nextpc !== 32'h10) begin err++; $display("FAIL jalr_wrap: got %h want 00000010", bus.d_nextpc); end
    idle();
  endtask

  task automatic test_branch_cond();
    logic [2:0]  bc [10] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011, 3'b100, 3'b101};
    logic [31:0] r1 [10] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'd1, 32'd1};
    logic [31:0] r2 [10] = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd2, 32'd1, 32'd1};
    logic        tk [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_pc;
    idle();
    for (int i = 0; i < 10; i++) begin
      bus.d_pc = 32'h600; bus.d_imm = 32'h80; bus.d_jump_code = 2'b01;
      bus.d_branch_code = bc[i]; bus.d_reg_data1 = r1[i]; bus.d_reg_data2 = r2[i];
      exp_pc = tk[i] ? 32'h680 : 32'h604;
      #1;
      vec++; if (bus.d_nextpc !== exp_pc) begin err++; $display("FAIL cond_%0d: bc=%b got %h want %h", i, bc[i], bus.d_nextpc, exp_pc); end
    end
    idle();
  endtask

  task automatic test_stall_mask();
    do_reset();
    bus.f_pc = 32'h100;
    drv(32'h100, 32'h104, 32'h40, 32'd3, 32'd3, 2'b01, 3'b000);
    bus.d_stall = 1'b1;
    #1;
    vec++; if (bus.d_fail_predict !== 1'b1) begin err++; $display("FAIL stall_fail: got %b want 1", bus.d_fail_predict); end
    tick();
    idle();
    #1;
    vec++; if (bus.f_pred_taken !== 1'b0) begin err++; $display("FAIL stall_taken: got %b want 0", bus.f_pred_taken); end
    vec++; if (perf_branches !== 32'd0) begin err++; $display("FAIL stall_perf: got %0d want 0", perf_branches); end
    drv(32'h100, 32'h104, 32'h40, 32'd3, 32'd3, 2'b01, 3'b000);
    bus.d_cannot_predict = 1'b1;
    #1;
    vec++; if (bus.d_fail_predict !== 1'b0) begin err++; $display("FAIL mask_fail: got %b want 0", bus.d_fail_predict); end
    tick();
    idle();
    #1;
    vec++; if (perf_branches !== 32'd1) begin err++; $display("FAIL mask_perf_br: got %0d want 1", perf_branches); end
    vec++; if (perf_mispredicts !== 32'd0) begin err++; $display("FAIL mask_perf_mis: got %0d want 0", perf_mispredicts); end
    vec++; if (bus.f_pred_taken !== 1'b1) begin err++; $display("FAIL mask_taken: got %b want 1", bus.f_pred_taken); end
  endtask

  task automatic test_aliasing();
    do_reset();
    drv(32'h100, 32'h104, 32'h40, 32'd9, 32'd9, 2'b01, 3'b000);
    tick();
    idle();
    bus.f_pc = 32'h140;
    #1;
    vec++; if (bus.f_pred_taken !== 1'b0) begin err++; $display("FAIL alias_taken: got %b want 0", bus.f_pred_taken); end
    vec++; if (bus.f_pred_pc !== 32'h144) begin err++; $display("FAIL alias_pc: got %h want 00000144", bus.f_pred_pc); end
    bus.f_pc = 32'h100;
    #1;
    vec++; if (bus.f_pred_taken !== 1'b1) begin err++; $display("FAIL alias_home_taken: got %b want 1", bus.f_pred_taken); end
    vec++; if (bus.f_pred_pc !== 32'h140) begin err++; $display("FAIL alias_home_pc: got %h want 00000140", bus.f_pred_pc); end
  endtask

  task automatic test_no_jump();
    do_reset();
    drv(32'h500, 32'h600, 32'h40, 32'd0, 32'd0, 2'b00, 3'b000);
    #1;
    vec++; if (bus.d_nextpc !== 32'h504) begin err++; $display("FAIL nojump_nextpc: got %h want 00000504", bus.d_nextpc); end
    vec++; if (bus.d_fail_predict !== 1'b1) begin err++; $display("FAIL nojump_fail: got %b want 1", bus.d_fail_predict); end
    tick();
    idle();
    #1;
    vec++; if (perf_branches !== 32'd0) begin err++; $display("FAIL nojump_perf: got %0d want 0", perf_branches); end
  endtask

  initial begin
    idle();
    bus.f_pc = 32'h0;
    test_reset();
    test_training();
    test_saturation();
    test_jumps();
    test_branch_cond();
    test_stall_mask();
    test_aliasing();
    test_no_jump();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
